// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two requesters, the arbiter and the register file write port.
interface regfile_wb_arbiter_if #(
  parameter int unsigned width = 32
);
  localparam int unsigned addr_w = 5;

  logic              req0_valid;
  logic [addr_w-1:0] req0_addr;
  logic [width-1:0]  req0_data;
  logic              req1_valid;
  logic [addr_w-1:0] req1_addr;
  logic [width-1:0]  req1_data;
  logic              req0_ready;
  logic              req1_ready;
  logic              hold;
  logic [addr_w-1:0] W_addr;
  logic [width-1:0]  W_data;
  logic              wr_enable;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  hold,
    output req0_ready, req1_ready,
    output W_addr, W_data, wr_enable
  );

  // Requester / environment side
  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output hold,
    input  req0_ready, req1_ready,
    input  W_addr, W_data, wr_enable
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-requester register-file writeback arbiter with round-robin tie break
// and a single registered write stage. Optional stall counter enabled by
// defining REGFILE_WB_ARB_STATS_EN.
module regfile_wb_arbiter #(
  parameter int unsigned width = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  bus
`ifdef REGFILE_WB_ARB_STATS_EN
  ,
  output logic [15:0]          stall_count
`endif
);
  localparam int unsigned addr_w = 5;

  // last_q = index of the most recent grant; reset to 1 so requester 0 wins the first tie
  logic              last_q;
  logic              wen_q;
  logic [addr_w-1:0] addr_q;
  logic [width-1:0]  data_q;

  logic              vld0;
  logic              vld1;
  logic              gnt0;
  logic              gnt1;
  logic              accept;
  logic [addr_w-1:0] acc_addr;
  logic [width-1:0]  acc_data;

  // Grant selection: sole valid wins, ties go to the requester not granted last
  always_comb begin
    vld0     = reset & ~bus.hold & bus.req0_valid;
    vld1     = reset & ~bus.hold & bus.req1_valid;
    gnt0     = vld0 & (~vld1 | last_q);
    gnt1     = vld1 & (~vld0 | ~last_q);
    accept   = gnt0 | gnt1;
    acc_addr = gnt1 ? bus.req1_addr : bus.req0_addr;
    acc_data = gnt1 ? bus.req1_data : bus.req0_data;
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.W_addr     = addr_q;
  assign bus.W_data     = data_q;
  assign bus.wr_enable  = wen_q;

  // Output stage and last-grant pointer; writes to register 0 are swallowed
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= 1'b1;
      wen_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      wen_q <= accept && (acc_addr != '0);
      if (accept) begin
        last_q <= gnt1;
      end
      if (accept && (acc_addr != '0)) begin
        addr_q <= acc_addr;
        data_q <= acc_data;
      end
    end
  end

`ifdef REGFILE_WB_ARB_STATS_EN
  localparam int unsigned cnt_w = 16;

  logic [1:0]     stall_inc;
  logic [cnt_w:0] stall_sum;
  logic [cnt_w-1:0] cnt_q;

  // Number of valid requesters left waiting this cycle, and the unsaturated next count
  always_comb begin
    stall_inc = 2'(bus.req0_valid & ~gnt0) + 2'(bus.req1_valid & ~gnt1);
    stall_sum = {1'b0, cnt_q} + (cnt_w+1)'(stall_inc);
  end

  // Saturating stall counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= stall_sum[cnt_w] ? '1 : stall_sum[cnt_w-1:0];
    end
  end

  assign stall_count = cnt_q;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_regfile_wb_arbiter;
  logic clk;
  logic reset;

  regfile_wb_arbiter_if #(.width(32)) ifc ();

`ifdef REGFILE_WB_ARB_STATS_EN
  logic [15:0] stall_count;
`endif

  regfile_wb_arbiter #(.width(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (ifc.slave)
`ifdef REGFILE_WB_ARB_STATS_EN
    ,
    .stall_count (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int          m_last;
  logic        m_wen;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  int          m_stall;
  int          last_grant;
  logic [36:0] mq[$];
  logic [36:0] wq[$];

  // Writes the register file would actually sample
  always @(posedge clk) begin
    if (ifc.wr_enable) wq.push_back({ifc.W_addr, ifc.W_data});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_wr_enable", 64'(ifc.wr_enable), 64'd0);
    chk("rst_W_addr", 64'(ifc.W_addr), 64'd0);
    chk("rst_W_data", 64'(ifc.W_data), 64'd0);
    chk("rst_req0_ready", 64'(ifc.req0_ready), 64'd0);
    chk("rst_req1_ready", 64'(ifc.req1_ready), 64'd0);
`ifdef REGFILE_WB_ARB_STATS_EN
    chk("rst_stall_count", 64'(stall_count), 64'd0);
`endif
    m_wen = 1'b0; m_waddr = '0; m_wdata = '0; m_last = 1; m_stall = 0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  // One clock of traffic: check readies before the edge, outputs after it
  task automatic cycle(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                       input logic h, output logic r0o, output logic r1o);
    int g;
    logic [4:0]  a;
    logic [31:0] d;
    ifc.req0_valid = v0; ifc.req0_addr = a0; ifc.req0_data = d0;
    ifc.req1_valid = v1; ifc.req1_addr = a1; ifc.req1_data = d1;
    ifc.hold = h;
    #1;
    g = -1;
    if (!h) begin
      if (v0 && v1) g = (m_last == 1) ? 0 : 1;
      else if (v0)  g = 0;
      else if (v1)  g = 1;
    end
    r0o = ifc.req0_ready;
    r1o = ifc.req1_ready;
    chk("req0_ready", 64'(r0o), 64'(g == 0));
    chk("req1_ready", 64'(r1o), 64'(g == 1));
    if (v0 && g != 0) m_stall++;
    if (v1 && g != 1) m_stall++;
    if (m_stall > 65535) m_stall = 65535;
    if (m_wen) mq.push_back({m_waddr, m_wdata});
    m_wen = 1'b0;
    if (g >= 0) begin
      m_last = g;
      a = (g == 1) ? a1 : a0;
      d = (g == 1) ? d1 : d0;
      if (a != 5'd0) begin
        m_wen = 1'b1; m_waddr = a; m_wdata = d;
      end
    end
    @(posedge clk); #1;
    chk("wr_enable", 64'(ifc.wr_enable), 64'(m_wen));
    chk("W_addr", 64'(ifc.W_addr), 64'(m_waddr));
    chk("W_data", 64'(ifc.W_data), 64'(m_wdata));
`ifdef REGFILE_WB_ARB_STATS_EN
    chk("stall_count", 64'(stall_count), 64'(m_stall));
`endif
    last_grant = g;
  endtask

  initial begin
    logic r0, r1;
    logic p0, p1;
    logic [4:0]  pa0, pa1;
    logic [31:0] pd0, pd1;
    int n;
    int grants[4];

    reset = 1'b0;
    ifc.req0_valid = 1'b1; ifc.req0_addr = 5'd1; ifc.req0_data = 32'h11;
    ifc.req1_valid = 1'b1; ifc.req1_addr = 5'd2; ifc.req1_data = 32'h22;
    ifc.hold = 1'b0;
    m_last = 1; m_wen = 1'b0; m_waddr = '0; m_wdata = '0; m_stall = 0; last_grant = -1;
    #2;
    do_reset();

    // Single requester write
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, r0, r1);
    chk("d25_ready0", 64'(r0), 64'd1);
    chk("d25_wr_enable", 64'(ifc.wr_enable), 64'd1);
    chk("d25_W_addr", 64'(ifc.W_addr), 64'd5);
    chk("d25_W_data", 64'(ifc.W_data), 64'hDEADBEEF);

    // Alternating grants under sustained contention
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 5'd3, 32'hA0 + 32'(i), 1'b1, 5'd7, 32'hB0 + 32'(i), 1'b0, r0, r1);
      grants[i] = last_grant;
      chk("d26_wr_enable", 64'(ifc.wr_enable), 64'd1);
      chk("d26_W_addr", 64'(ifc.W_addr), (i % 2 == 0) ? 64'd3 : 64'd7);
    end
    chk("d26_grant0", 64'(grants[0]), 64'd0);
    chk("d26_grant1", 64'(grants[1]), 64'd1);
    chk("d26_grant2", 64'(grants[2]), 64'd0);
    chk("d26_grant3", 64'(grants[3]), 64'd1);

    // Write to register zero is accepted but never issued
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1234, 1'b0, r0, r1);
    chk("d27_ready1", 64'(r1), 64'd1);
    chk("d27_wr_enable", 64'(ifc.wr_enable), 64'd0);

    // Hold blocks grants; accept when it drops
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 5'd4, 32'h4444, 1'b0, 5'd0, 32'h0, 1'b1, r0, r1);
      chk("d28_ready0_held", 64'(r0), 64'd0);
    end
`ifdef REGFILE_WB_ARB_STATS_EN
    chk("d28_stall3", 64'(stall_count), 64'd3);
`endif
    cycle(1'b1, 5'd4, 32'h4444, 1'b0, 5'd0, 32'h0, 1'b0, r0, r1);
    chk("d28_ready0_release", 64'(r0), 64'd1);
`ifdef REGFILE_WB_ARB_STATS_EN
    chk("d28_stall3_after", 64'(stall_count), 64'd3);
`endif

    // Reset right after an accept discards the pending write
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, r0, r1);
    n = wq.size() + 1;
    cycle(1'b1, 5'd9, 32'h99999999, 1'b0, 5'd0, 32'h0, 1'b0, r0, r1);
    n = wq.size();
    ifc.req0_valid = 1'b0;
    do_reset();
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, r0, r1);
    chk("d29_wr_enable", 64'(ifc.wr_enable), 64'd0);
    chk("d29_W_addr", 64'(ifc.W_addr), 64'd0);
    chk("d29_W_data", 64'(ifc.W_data), 64'd0);
    chk("d29_no_wr_9", 64'(wq.size()), 64'(n));

    // Same-address back-to-back grants: later grant wins
    do_reset();
    cycle(1'b1, 5'd12, 32'hAAAA0001, 1'b1, 5'd12, 32'hBBBB0002, 1'b0, r0, r1);
    chk("d30_first_grant", 64'(r0), 64'd1);
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hBBBB0002, 1'b0, r0, r1);
    chk("d30_second_grant", 64'(r1), 64'd1);
    n = wq.size();
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, r0, r1);
    chk("d30_two_writes", 64'(wq.size() - n), 64'd1);
    chk("d30_final_data", 64'(wq[wq.size()-1]), 64'({5'd12, 32'hBBBB0002}));

    // Randomized traffic with requesters that hold requests until accepted
    p0 = 1'b0; p1 = 1'b0; pa0 = '0; pa1 = '0; pd0 = '0; pd1 = '0;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        do_reset();
        p0 = 1'b0; p1 = 1'b0;
      end
      if (!p0 && $urandom_range(0, 2) != 0) begin
        p0 = 1'b1; pa0 = 5'($urandom_range(0, 31)); pd0 = $urandom;
      end
      if (!p1 && $urandom_range(0, 2) != 0) begin
        p1 = 1'b1; pd1 = $urandom;
        pa1 = ($urandom_range(0, 3) == 0) ? pa0 : 5'($urandom_range(0, 31));
      end
      cycle(p0, pa0, pd0, p1, pa1, pd1, 1'($urandom_range(0, 4) == 0), r0, r1);
      if (last_grant == 0) p0 = 1'b0;
      if (last_grant == 1) p1 = 1'b0;
    end
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, r0, r1);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, r0, r1);

    // Every issued write matches the model's write stream in order
    chk("write_count", 64'(wq.size()), 64'(mq.size()));
    for (int i = 0; i < wq.size() && i < mq.size(); i++) begin
      chk("write_stream", 64'(wq[i]), 64'(mq[i]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter: width, default 32, data width of all write-data paths.
REQ-002 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: req0_valid  input  1; req0_addr  input  5; req0_data  input  width  -- writeback request 0 (ALU path).
REQ-005 SHALL have ports: req1_valid  input  1; req1_addr  input  5; req1_data  input  width  -- writeback request 1 (load/multi-cycle path).
REQ-006 SHALL have ports: req0_ready  output  1; req1_ready  output  1  -- grant/accept strobes.
REQ-007 SHALL have port: hold  input  1  pipeline freeze; no new grants while high.
REQ-008 SHALL have ports: W_addr  output  5; W_data  output  width; wr_enable  output  1  -- regfile write port.

Function
REQ-009 SHALL accept a transfer on requester n in a cycle where reqn_valid and reqn_ready are both high.
REQ-010 SHALL drive reqn_ready combinationally; at most one ready high per cycle; both low while hold is high.
REQ-011 SHALL grant the sole valid requester when only one is valid.
REQ-012 SHALL, when both are valid, grant the requester not marked by a 1-bit last-grant pointer; pointer updates to the granted index on every accept.
REQ-013 SHALL register accepted addr/data into an output stage; W_addr/W_data/wr_enable reflect the accept exactly one cycle later (latency 1).
REQ-014 SHALL pulse wr_enable for exactly one cycle per accepted transfer, except when the accepted addr is 0, where wr_enable stays low (register $zero never written).
REQ-015 SHALL hold W_addr/W_data at their last value while wr_enable is low.
REQ-016 SHALL, when both requesters target the same address in back-to-back grants, write both in grant order (later grant wins).
REQ-017 SHALL allow back-to-back accepts every cycle (no bubble) when hold is low.
REQ-018 SHALL still complete an output-stage write already registered when hold rises (hold blocks only new grants).
REQ-019 SHALL require requesters to keep valid/addr/data stable until accepted; no internal request buffering.

Reset
REQ-020 SHALL on reset low: wr_enable=0, W_addr=0, W_data=0, last-grant pointer=1 (requester 0 wins first tie), req0_ready=req1_ready=0.
REQ-021 SHALL discard any write pending in the output stage when reset asserts mid-operation; no wr_enable pulse after reset deassertion unless a new accept occurs.
REQ-022 SHALL begin granting on the first rising clk edge after reset deasserts.

Configuration
REQ-023 SHALL, with macro REGFILE_WB_ARB_STATS_EN defined, add output stall_count (16-bit) incrementing each cycle a valid requester is not accepted (+2 when both are stalled, +1 otherwise), saturating at 16'hFFFF and reset to 0.
REQ-024 SHALL, without REGFILE_WB_ARB_STATS_EN, omit the stall_count port and counter logic entirely; all other behaviour identical.

Verification
REQ-025 SHALL cover: req0 only, addr=5, data=32'hDEADBEEF -> req0_ready same cycle; next cycle wr_enable=1, W_addr=5, W_data=32'hDEADBEEF.
REQ-026 SHALL cover: both valid held 4 cycles after reset (addr 3/7) -> grants 0,1,0,1; wr_enable high 4 consecutive cycles, W_addr 3,7,3,7.
REQ-027 SHALL cover: req1 valid addr=0 data=32'h1234 -> req1_ready=1, wr_enable stays 0 next cycle.
REQ-028 SHALL cover: hold=1 for 3 cycles with req0 valid -> req0_ready=0 throughout; accept in the cycle hold drops; with STATS_EN stall_count=3.
REQ-029 SHALL cover: reset pulsed low in the cycle after an accept of addr=9 -> wr_enable=0, W_addr=0, W_data=0 after reset; no write of addr 9.
REQ-030 SHALL cover: both valid, same addr=12, data A then B -> wr_enable two cycles, final W_data equals data of second grant.
